apb_sram_ctrl: RTL and testbench
================================

# apb_sram_ctrl

Parametrised APB slave that bridges an APB bus to a single-port synchronous SRAM macro. It is the next generation of the team's APB-to-SRAM controller and adds configurable data width, depth and SRAM read latency. It inserts read wait states, supports byte-lane writes via `pstrb`, and flags misaligned or out-of-range accesses with `pslverr`. It sits between the APB bridge and one SRAM instance, and the SRAM is instantiated outside this block.

## Interface
Parameters:
- `DATA_W`, 32: APB and SRAM data width. Must be a multiple of 8. `STRB_W = DATA_W/8`, `LSB = log2(STRB_W)`.
- `ADDR_W`, 12: `paddr` width, byte address.
- `DEPTH`, 1024: SRAM words. `MEM_AW = $clog2(DEPTH)`. Requires `DEPTH <= 2^(ADDR_W-LSB)`.
- `RD_LAT`, 1: SRAM read latency in cycles from the edge sampling `mem_en` to valid `mem_rdata`. Must be at least 1.

Ports:
- `pclk` in 1: the only clock, rising edge.
- `prstn` in 1: reset, synchronous, active-low.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in `ADDR_W`: byte address.
- `pwdata` in `DATA_W`: write data.
- `pstrb` in `STRB_W`: write byte strobes.
- `pready` out 1: transfer complete.
- `prdata` out `DATA_W`: read data.
- `pslverr` out 1: error response, valid only while `pready`=1.
- `mem_en` out 1: SRAM access strobe, one cycle per access.
- `mem_we` out 1: SRAM write enable.
- `mem_be` out `STRB_W`: SRAM byte enables.
- `mem_addr` out `MEM_AW`: SRAM word address.
- `mem_wdata` out `DATA_W`: SRAM write data.
- `mem_rdata` in `DATA_W`: SRAM read data.

## Operation
- States: IDLE, WR, RD, ERR. Counter `cnt` is `$clog2(RD_LAT+1)` bits wide.
- **Decode.** Decode runs on the edge that ends an APB setup cycle (`psel`=1, `penable`=0), and only in IDLE or at the end of a completed transfer.
  - `idx = paddr[ADDR_W-1:LSB]`.
  - Error condition: `paddr[LSB-1:0] != 0` or `idx >= DEPTH`. Go to ERR and issue no SRAM access.
  - Otherwise, if `pwrite`=1, go to WR. Register `mem_en`=1, `mem_we`=1, `mem_be=pstrb`, `mem_addr=idx`, `mem_wdata=pwdata`.
  - Otherwise go to RD. Register `mem_en`=1, `mem_we`=0, `mem_be`=all-ones, `mem_addr=idx`, and load `cnt=RD_LAT`.
- **Write with zero strobes.** If `pstrb`=0 on a write, take the WR path but force `mem_en`=0. This is a no-op write with `pslverr`=0.
- **SRAM strobes.**
  - `mem_en`/`mem_we` are registered and high for exactly one cycle, the first access cycle.
  - `mem_addr`, `mem_wdata` and `mem_be` hold their values until the next decode.
- **WR.** `pready`=1 in the first access cycle (no wait states). Return to IDLE on the next edge.
- **RD.**
  - `cnt` decrements each access cycle.
  - `pready`=1 in the cycle where `cnt` reaches 0. In that cycle `prdata=mem_rdata` (combinational pass-through).
  - Return to IDLE on the next edge.
- **ERR.** `pready`=1 and `pslverr`=1 in the first access cycle, with `prdata`=0. Return to IDLE.
- **`prdata` gating.** `prdata` is forced to 0 whenever `pready`=0 or `pslverr`=1.
- **Back-to-back transfers.** A new setup cycle immediately after the `pready` cycle is decoded normally, with no idle cycle required.
- **Abort.** If `psel`=0 in any non-IDLE state, go to IDLE on the next edge with `pready`=0. A read already issued to the SRAM completes inside the SRAM, and its data is discarded.
- **Ignored inputs.** `penable` without `psel` is ignored. In IDLE, `penable`=1 does not start a transfer; only a proper setup cycle does.

## Timing
- **Reset.** With `prstn`=0 at a rising edge, on the following cycle:
  - state is IDLE and `cnt`=0;
  - `pready`=0, `pslverr`=0, `prdata`=0;
  - `mem_en`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-transfer.** Any transfer in progress is dropped. No `pready` is issued for it.
- **Cycle numbering.** T0 is the setup cycle and T1 is the first access cycle.
  - Write and error transfers complete in T1.
  - Reads complete in T(RD_LAT), which is RD_LAT wait-state-free cycles for RD_LAT=1 and RD_LAT-1 wait states beyond T1 in general.
- **`pready` outputs.** `pready` and `pslverr` are decoded combinationally from state and `cnt`. They do not depend combinationally on `paddr` or `pwdata`.
- **Peak throughput.** One write per 2 cycles. One read per RD_LAT+1 cycles.

## Test plan
- **Reset.** Assert `prstn`=0 for 2 cycles with `psel`=1 → all outputs 0. First setup after release decodes normally.
- **Write then read, RD_LAT=1.**
  - Write 0xDEADBEEF to 0x010 with `pstrb`=0xF → `mem_en`/`mem_we` high for one cycle in T1 with `mem_addr`=4, and `pready` in T1.
  - Read 0x010 → `pready` in T1 with `prdata`=0xDEADBEEF.
- **Byte lanes.** Write 0x11223344 with `pstrb`=0x5 to a word that holds 0xDEADBEEF → `mem_be`=0x5, and a readback gives 0xDE22BE44. A write with `pstrb`=0 gives no `mem_en`, `pready` in T1 and `pslverr`=0.
- **Read latency.** With RD_LAT=3, a read of 0x020 → `pready` low in T1 and T2, high in T3 with the correct data. A back-to-back read following it completes 4 cycles later.
- **Errors (DEPTH=512).**
  - Read 0x800 → `pready`=`pslverr`=1 in T1, `prdata`=0, no `mem_en`.
  - Write to 0x003 → same error response, and memory is unchanged.
- **Abort.** With RD_LAT=3, drop `psel` in T1 of a read → IDLE next cycle with no `pready`. An immediate new write succeeds.

Source files
------------

// File: rtl/apb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// apb_sram_ctrl
// APB slave that bridges APB transfers onto one single-port synchronous SRAM
// macro (instantiated outside this block). Writes finish in the first access
// cycle. Reads insert wait states so that the transfer completes RD_LAT
// access cycles after setup. Byte-lane writes use pstrb. Misaligned and
// out-of-range accesses get an error response and never reach the SRAM.
//
// Ports
//   pclk, prstn          : clock (rising edge), synchronous active-low reset
//   psel/penable/pwrite  : APB control
//   paddr, pwdata, pstrb : APB byte address, write data, write byte strobes
//   pready/prdata/pslverr: APB response
//   mem_en/mem_we        : SRAM access strobe and write enable (1-cycle pulse)
//   mem_be/mem_addr      : SRAM byte enables and word address
//   mem_wdata/mem_rdata  : SRAM write and read data
// -----------------------------------------------------------------------------
module apb_sram_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  localparam int STRB_W = DATA_W / 8,
  localparam int LSB    = $clog2(STRB_W),
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [STRB_W-1:0]   r_mem_be;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [ADDR_W-1:0]   w_idx;
  logic                w_misalign;
  logic                w_range_err;
  logic                w_err;
  logic                w_pready;
  logic                w_pslverr;
  logic                w_decode;

  // Address decode: word index, alignment and range checks.
  assign w_idx       = paddr >> LSB;
  assign w_misalign  = |(paddr & ALIGN_MASK);
  assign w_range_err = ({1'b0, w_idx} >= (ADDR_W + 1)'(DEPTH));
  assign w_err       = w_misalign | w_range_err;

  // Response is a pure function of state and counter so it never depends
  // combinationally on the address or data buses. A read completes in the
  // access cycle where the counter is about to reach zero.
  assign w_pready  = (r_state == ST_WR) || (r_state == ST_ERR) ||
                     ((r_state == ST_RD) && (r_cnt == CNT_W'(1)));
  assign w_pslverr = (r_state == ST_ERR);

  // A setup cycle is accepted in IDLE or in the cycle that completes a transfer.
  assign w_decode = psel && !penable && ((r_state == ST_IDLE) || w_pready);

  assign pready    = w_pready;
  assign pslverr   = w_pslverr;
  assign prdata    = (w_pready && !w_pslverr) ? mem_rdata : {DATA_W{1'b0}};
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Transfer FSM, wait-state counter and registered SRAM request.
  always_ff @(posedge pclk) begin
    if (!prstn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= {STRB_W{1'b0}};
      r_mem_addr  <= {MEM_AW{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
    end else begin
      // SRAM strobes are single-cycle pulses; address/data/enables hold.
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      if (w_decode) begin
        if (w_err) begin
          r_state <= ST_ERR;
          r_cnt   <= {CNT_W{1'b0}};
        end else if (pwrite) begin
          r_state     <= ST_WR;
          // All-zero strobes complete normally but never touch the SRAM.
          r_mem_en    <= |pstrb;
          r_mem_we    <= 1'b1;
          r_mem_be    <= pstrb;
          r_mem_addr  <= w_idx[MEM_AW-1:0];
          r_mem_wdata <= pwdata;
          r_cnt       <= {CNT_W{1'b0}};
        end else begin
          r_state    <= ST_RD;
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_be   <= {STRB_W{1'b1}};
          r_mem_addr <= w_idx[MEM_AW-1:0];
          r_cnt      <= CNT_W'(RD_LAT);
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_WR, ST_ERR: begin
            r_state <= ST_IDLE;
          end
          ST_RD: begin
            // Dropping psel abandons the read; any SRAM data is discarded.
            if (!psel || (r_cnt == CNT_W'(1))) begin
              r_state <= ST_IDLE;
              r_cnt   <= {CNT_W{1'b0}};
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_sram_ctrl
// Directed bench for apb_sram_ctrl. Two instances share clock and reset:
// index 0 has RD_LAT=1, index 1 has RD_LAT=3; both have DEPTH=512. Each has
// a small byte-enabled memory model behind its SRAM port.
// -----------------------------------------------------------------------------
module tb_apb_sram_ctrl;

  logic        pclk;
  logic        prstn;
  logic        psel_v    [2];
  logic        penable_v [2];
  logic        pwrite_v  [2];
  logic [11:0] paddr_v   [2];
  logic [31:0] pwdata_v  [2];
  logic [3:0]  pstrb_v   [2];

  wire         pready_w    [2];
  wire  [31:0] prdata_w    [2];
  wire         pslverr_w   [2];
  wire         mem_en_w    [2];
  wire         mem_we_w    [2];
  wire  [3:0]  mem_be_w    [2];
  wire  [8:0]  mem_addr_w  [2];
  wire  [31:0] mem_wdata_w [2];
  wire  [31:0] mem_rdata_w [2];

  int checks;
  int errors;
  int cyc;

  // results of the last apb() call
  int          n_lat;
  int          en_cnt;
  int          ready_cyc;
  logic [31:0] rdata;
  logic        err;
  logic        setup_rdy;
  logic        t1_en;
  logic        t1_we;
  logic [3:0]  t1_be;
  logic [8:0]  t1_addr;
  logic [31:0] t1_wdata;
  int          first_ready;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // cycle counter for throughput measurements
  always @(posedge pclk) cyc <= cyc + 1;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [512];

    apb_sram_ctrl #(
      .DATA_W(32), .ADDR_W(12), .DEPTH(512), .RD_LAT(LAT)
    ) u_dut (
      .pclk      (pclk),
      .prstn     (prstn),
      .psel      (psel_v[g]),
      .penable   (penable_v[g]),
      .pwrite    (pwrite_v[g]),
      .paddr     (paddr_v[g]),
      .pwdata    (pwdata_v[g]),
      .pstrb     (pstrb_v[g]),
      .pready    (pready_w[g]),
      .prdata    (prdata_w[g]),
      .pslverr   (pslverr_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_be    (mem_be_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );

    // byte-enabled SRAM model; read port follows the held address
    always @(posedge pclk) begin
      if (mem_en_w[g] && mem_we_w[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_w[g][b]) mem[mem_addr_w[g]][8*b +: 8] <= mem_wdata_w[g][8*b +: 8];
        end
      end
    end
    assign mem_rdata_w[g] = mem[mem_addr_w[g]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One APB transfer on instance d. Called #1 after a rising edge; the setup
  // cycle is that same cycle. With idle_after=0 psel stays high so the next
  // call forms a back-to-back transfer.
  task automatic apb(input int d, input logic wr, input logic [11:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input logic idle_after);
    psel_v[d] = 1'b1; penable_v[d] = 1'b0; pwrite_v[d] = wr;
    paddr_v[d] = a; pwdata_v[d] = wd; pstrb_v[d] = st;
    en_cnt = 0; n_lat = 99; rdata = 32'h0; err = 1'b0;
    @(negedge pclk);
    setup_rdy = pready_w[d];
    @(posedge pclk); #1;
    penable_v[d] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge pclk);
      if (k == 1) begin
        t1_en = mem_en_w[d]; t1_we = mem_we_w[d]; t1_be = mem_be_w[d];
        t1_addr = mem_addr_w[d]; t1_wdata = mem_wdata_w[d];
      end
      en_cnt += int'(mem_en_w[d]);
      if (pready_w[d]) begin
        n_lat = k; rdata = prdata_w[d]; err = pslverr_w[d]; ready_cyc = cyc;
        break;
      end
      @(posedge pclk); #1;
    end
    if (n_lat != 99) begin
      @(posedge pclk); #1;
    end
    penable_v[d] = 1'b0;
    if (idle_after) begin
      psel_v[d] = 1'b0;
      @(negedge pclk);
      en_cnt += int'(mem_en_w[d]);
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    prstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel_v[i] = 1'b1; penable_v[i] = 1'b0; pwrite_v[i] = 1'b1;
      paddr_v[i] = 12'h010; pwdata_v[i] = 32'hFFFF_FFFF; pstrb_v[i] = 4'hF;
    end

    // reset for two cycles with psel high
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check_eq("rst_pready",  32'(pready_w[0]),   32'h0);
    check_eq("rst_pslverr", 32'(pslverr_w[0]),  32'h0);
    check_eq("rst_prdata",  prdata_w[0],        32'h0);
    check_eq("rst_mem_en",  32'(mem_en_w[0]),   32'h0);
    check_eq("rst_mem_we",  32'(mem_we_w[0]),   32'h0);
    check_eq("rst_mem_be",  32'(mem_be_w[0]),   32'h0);
    check_eq("rst_mem_addr",32'(mem_addr_w[0]), 32'h0);
    check_eq("rst_mem_wd",  mem_wdata_w[0],     32'h0);
    check_eq("rst_pready1", 32'(pready_w[1]),   32'h0);
    check_eq("rst_mem_en1", 32'(mem_en_w[1]),   32'h0);
    @(posedge pclk); #1;
    prstn = 1'b1;
    psel_v[1] = 1'b0;

    // ---- RD_LAT=1 instance ----
    apb(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 4'hF, 1'b1);
    check_eq("wr_lat",    32'(n_lat),   32'd1);
    check_eq("wr_slverr", 32'(err),     32'h0);
    check_eq("wr_t1_en",  32'(t1_en),   32'h1);
    check_eq("wr_t1_we",  32'(t1_we),   32'h1);
    check_eq("wr_t1_addr",32'(t1_addr), 32'h4);
    check_eq("wr_t1_be",  32'(t1_be),   32'hF);
    check_eq("wr_t1_wd",  t1_wdata,     32'hDEAD_BEEF);
    check_eq("wr_en_cnt", 32'(en_cnt),  32'd1);

    apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b1);
    check_eq("rd1_lat",   32'(n_lat),   32'd1);
    check_eq("rd1_data",  rdata,        32'hDEAD_BEEF);
    check_eq("rd1_slverr",32'(err),     32'h0);
    check_eq("rd1_t1_be", 32'(t1_be),   32'hF);
    check_eq("rd1_t1_we", 32'(t1_we),   32'h0);

    apb(0, 1'b1, 12'h010, 32'h1122_3344, 4'h5, 1'b1);
    check_eq("bl_be",     32'(t1_be),   32'h5);
    apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b1);
    check_eq("bl_data",   rdata,        32'hDE22_BE44);

    apb(0, 1'b1, 12'h010, 32'hFFFF_FFFF, 4'h0, 1'b1);
    check_eq("z_lat",     32'(n_lat),   32'd1);
    check_eq("z_slverr",  32'(err),     32'h0);
    check_eq("z_en_cnt",  32'(en_cnt),  32'd0);
    apb(0, 1'b0, 12'h010, 32'h0, 4'h0, 1'b1);
    check_eq("z_data",    rdata,        32'hDE22_BE44);

    apb(0, 1'b0, 12'h800, 32'h0, 4'h0, 1'b1);
    check_eq("oor_lat",   32'(n_lat),   32'd1);
    check_eq("oor_slverr",32'(err),     32'h1);
    check_eq("oor_prdata",rdata,        32'h0);
    check_eq("oor_en_cnt",32'(en_cnt),  32'd0);

    apb(0, 1'b1, 12'h000, 32'hCAFE_F00D, 4'hF, 1'b1);
    apb(0, 1'b1, 12'h003, 32'h0000_0000, 4'hF, 1'b1);
    check_eq("mis_lat",   32'(n_lat),   32'd1);
    check_eq("mis_slverr",32'(err),     32'h1);
    check_eq("mis_en_cnt",32'(en_cnt),  32'd0);
    apb(0, 1'b0, 12'h000, 32'h0, 4'h0, 1'b1);
    check_eq("mis_keep",  rdata,        32'hCAFE_F00D);

    // ---- RD_LAT=3 instance ----
    apb(1, 1'b1, 12'h020, 32'hA5A5_5A5A, 4'hF, 1'b1);
    apb(1, 1'b1, 12'h024, 32'h0BAD_F00D, 4'hF, 1'b1);
    apb(1, 1'b0, 12'h020, 32'h0, 4'h0, 1'b0);
    check_eq("rd3_lat",   32'(n_lat),   32'd3);
    check_eq("rd3_data",  rdata,        32'hA5A5_5A5A);
    check_eq("rd3_en_cnt",32'(en_cnt),  32'd1);
    first_ready = ready_cyc;
    apb(1, 1'b0, 12'h024, 32'h0, 4'h0, 1'b1);
    check_eq("b2b_gap",   32'(ready_cyc - first_ready), 32'd4);
    check_eq("b2b_data",  rdata,        32'h0BAD_F00D);

    // abort: psel dropped in T1 of a read
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b0; paddr_v[1] = 12'h020;
    @(posedge pclk); #1;
    psel_v[1] = 1'b0;
    @(negedge pclk);
    check_eq("abort_t1",  32'(pready_w[1]), 32'h0);
    @(posedge pclk); #1;
    apb(1, 1'b1, 12'h028, 32'h1234_5678, 4'hF, 1'b1);
    check_eq("abort_t2",  32'(setup_rdy), 32'h0);
    check_eq("abort_wr",  32'(n_lat),   32'd1);
    check_eq("abort_slv", 32'(err),     32'h0);
    apb(1, 1'b0, 12'h028, 32'h0, 4'h0, 1'b1);
    check_eq("abort_rd",  rdata,        32'h1234_5678);

    // reset in the middle of a read
    psel_v[1] = 1'b1; penable_v[1] = 1'b0; pwrite_v[1] = 1'b0; paddr_v[1] = 12'h020;
    @(posedge pclk); #1;
    penable_v[1] = 1'b1;
    prstn = 1'b0;
    @(negedge pclk);
    check_eq("mrst_t1",   32'(pready_w[1]), 32'h0);
    @(posedge pclk); #1;
    @(negedge pclk);
    check_eq("mrst_rdy",  32'(pready_w[1]), 32'h0);
    check_eq("mrst_addr", 32'(mem_addr_w[1]), 32'h0);
    @(posedge pclk); #1;
    prstn = 1'b1; psel_v[1] = 1'b0; penable_v[1] = 1'b0;
    @(posedge pclk); #1;
    apb(1, 1'b0, 12'h028, 32'h0, 4'h0, 1'b1);
    check_eq("post_lat",  32'(n_lat),   32'd3);
    check_eq("post_data", rdata,        32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
